// File: rtl/alu_reservation_station.sv
// Purpose: ALU reservation station; holds dispatched ops until both sources are ready and issues the oldest eligible entry.
// Latency: an op that is ready at dispatch issues the next cycle; a writeback wakeup makes its entry eligible the next cycle.
// Backpressure: dispatch_ready drops while every slot is occupied; issue_ready=0 keeps the selected entry resident.
module alu_reservation_station #(
   parameter int RS_DEPTH       = 4,
   parameter int NUM_WB         = 2,
   parameter int PHYS_REG_WIDTH = 6
) (
   input  logic                             CLK,
   input  logic                             nRST,
   input  logic                             dispatch_valid,
   output logic                             dispatch_ready,
   input  logic [4+2*(PHYS_REG_WIDTH+2)+PHYS_REG_WIDTH+16+5-1:0] dispatch_struct,
   input  logic [NUM_WB-1:0]                WB_valid,
   input  logic [NUM_WB*PHYS_REG_WIDTH-1:0] WB_phys_reg_tag,
   input  logic                             flush,
   output logic                             issue_valid,
   input  logic                             issue_ready,
   output logic [3:0]                       issue_op,
   output logic [PHYS_REG_WIDTH-1:0]        issue_source_0_tag,
   output logic [PHYS_REG_WIDTH-1:0]        issue_source_1_tag,
   output logic [PHYS_REG_WIDTH-1:0]        issue_dest_phys_reg_tag,
   output logic [15:0]                      issue_imm16,
   output logic [4:0]                       issue_ROB_index
);

   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   typedef struct packed {
      logic                      needed;
      logic                      ready;
      logic [PHYS_REG_WIDTH-1:0] tag;
   } src_t;

   typedef struct packed {
      logic [3:0]                op;
      src_t                      source_0;
      src_t                      source_1;
      logic [PHYS_REG_WIDTH-1:0] dest_phys_reg_tag;
      logic [15:0]               imm16;
      logic [4:0]                ROB_index;
   } rs_in_t;

   // True when any valid writeback bus carries this tag.
   function automatic logic wb_match(input logic [PHYS_REG_WIDTH-1:0] tag,
                                     input logic [NUM_WB-1:0] vld,
                                     input logic [NUM_WB*PHYS_REG_WIDTH-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int b = 0; b < NUM_WB; b++) begin
         if (vld[b] && (tags[b*PHYS_REG_WIDTH +: PHYS_REG_WIDTH] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic src_ok(input src_t s);
      return !s.needed || s.ready;
   endfunction

   // Registered state. age[k][j]=1 means entry j is older than entry k.
   logic [RS_DEPTH-1:0] valid;
   rs_in_t              ent [RS_DEPTH];
   logic [RS_DEPTH-1:0] age [RS_DEPTH];

   rs_in_t              din;
   rs_in_t              new_ent;
   logic [RS_DEPTH-1:0] eligible;
   logic [IDX_W-1:0]    sel_idx;
   logic [IDX_W-1:0]    alloc_idx;
   logic [RS_DEPTH-1:0] issue_mask;
   logic                issue_fire;
   logic                accept;

   assign din = dispatch_struct;

   // Incoming entry, with sources woken by writebacks landing in the dispatch cycle.
   always_comb begin
      new_ent = din;
      new_ent.source_0.ready = din.source_0.ready |
         (din.source_0.needed & wb_match(din.source_0.tag, WB_valid, WB_phys_reg_tag));
      new_ent.source_1.ready = din.source_1.ready |
         (din.source_1.needed & wb_match(din.source_1.tag, WB_valid, WB_phys_reg_tag));
   end

   // An entry is eligible once it is valid and neither source is still waiting.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         eligible[i] = valid[i] && src_ok(ent[i].source_0) && src_ok(ent[i].source_1);
      end
   end

   // Oldest-first pick: the eligible entry with no older eligible entry.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (eligible[i] && ((age[i] & eligible) == '0)) sel_idx = IDX_W'(i);
      end
   end

   // Lowest-index free slot receives the next dispatch.
   always_comb begin
      alloc_idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) alloc_idx = IDX_W'(i);
      end
   end

   assign dispatch_ready = nRST && !(&valid);
   assign issue_valid    = nRST && !flush && (|eligible);
   assign issue_fire     = issue_valid && issue_ready;
   assign accept         = dispatch_valid && dispatch_ready && !flush;
   assign issue_mask     = issue_fire ? (RS_DEPTH'(1) << sel_idx) : '0;

   // Issue payload, forced to zero whenever nothing is presented.
   always_comb begin
      issue_op                = '0;
      issue_source_0_tag      = '0;
      issue_source_1_tag      = '0;
      issue_dest_phys_reg_tag = '0;
      issue_imm16             = '0;
      issue_ROB_index         = '0;
      if (issue_valid) begin
         issue_op                = ent[sel_idx].op;
         issue_source_0_tag      = ent[sel_idx].source_0.tag;
         issue_source_1_tag      = ent[sel_idx].source_1.tag;
         issue_dest_phys_reg_tag = ent[sel_idx].dest_phys_reg_tag;
         issue_imm16             = ent[sel_idx].imm16;
         issue_ROB_index         = ent[sel_idx].ROB_index;
      end
   end

   // Entry, wakeup and age-matrix update; reset and flush both empty the station.
   always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
         valid <= '0;
         for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid[i]) begin
               if (ent[i].source_0.needed &&
                   wb_match(ent[i].source_0.tag, WB_valid, WB_phys_reg_tag))
                  ent[i].source_0.ready <= 1'b1;
               if (ent[i].source_1.needed &&
                   wb_match(ent[i].source_1.tag, WB_valid, WB_phys_reg_tag))
                  ent[i].source_1.ready <= 1'b1;
            end
            // Freed entry is no longer older than anyone.
            if (issue_fire) age[i][sel_idx] <= 1'b0;
         end
         if (issue_fire) valid[sel_idx] <= 1'b0;
         // The free slot is never the issuing slot, so both updates coexist.
         if (accept) begin
            valid[alloc_idx] <= 1'b1;
            ent[alloc_idx]   <= new_ent;
            age[alloc_idx]   <= valid & ~issue_mask;
         end
      end
   end

endmodule
